// File: rtl/imm_decode_stage.sv
// Registered RV32I/RV64I immediate decoder with a 2-entry main/skid buffer.
// Decode happens on the input side, so both buffer entries hold finished results.
module imm_decode_stage #(
   parameter int XLEN   = 64,
   parameter int TAG_W  = 32,
   parameter bit CSR_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       out_type,
   output logic [XLEN-1:0]  out_imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal
);

   localparam logic [2:0] T_S    = 3'b000;
   localparam logic [2:0] T_U    = 3'b001;
   localparam logic [2:0] T_J    = 3'b010;
   localparam logic [2:0] T_I    = 3'b011;
   localparam logic [2:0] T_B    = 3'b100;
   localparam logic [2:0] T_Z    = 3'b101;
   localparam logic [2:0] T_NONE = 3'b111;

   typedef struct packed {
      logic [2:0]       typ;
      logic [XLEN-1:0]  imm;
      logic [TAG_W-1:0] tag;
      logic             illegal;
   } entry_t;

   // Encoding is {main_v, skid_v}.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b10,
      ST_FULL  = 2'b11
   } state_t;

   localparam entry_t RST_ENTRY = '{typ: T_NONE, imm: '0, tag: '0, illegal: 1'b0};

   function automatic entry_t decode(input logic [31:0] inst, input logic [TAG_W-1:0] tag);
      entry_t     e;
      logic [31:0] imm32;
      e.typ     = T_NONE;
      e.illegal = 1'b0;
      e.tag     = tag;
      e.imm     = '0;
      imm32     = 32'd0;
      case (inst[6:0])
         7'b0010011, 7'b0000011, 7'b1100111: e.typ = T_I;
         7'b0011011: begin
            if (XLEN == 64) e.typ = T_I;
            else            e.illegal = 1'b1;
         end
         7'b0110111, 7'b0010111: e.typ = T_U;
         7'b1101111: e.typ = T_J;
         7'b0100011: e.typ = T_S;
         7'b1100011: e.typ = T_B;
         7'b0110011: e.typ = T_NONE;
         7'b0111011: begin
            if (XLEN == 64) e.typ = T_NONE;
            else            e.illegal = 1'b1;
         end
         7'b1110011: begin
            if (CSR_EN) e.typ = inst[14] ? T_Z : T_I;
            else        e.typ = T_NONE;
         end
         default: e.illegal = 1'b1;
      endcase
      case (e.typ)
         T_I:     imm32 = {{20{inst[31]}}, inst[31:20]};
         T_S:     imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         T_B:     imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         T_U:     imm32 = {inst[31:12], 12'd0};
         T_J:     imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm32 = 32'd0;
      endcase
      // zimm is the only zero-extended form; everything else sign-extends from bit 31.
      if (e.typ == T_Z) e.imm = XLEN'(inst[19:15]);
      else              e.imm = XLEN'($signed(imm32));
      return e;
   endfunction

   state_t state_q, state_d;
   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   entry_t new_s;
   logic   accept_s;
   logic   drain_s;

   assign in_ready    = (state_q != ST_FULL);
   assign out_valid   = (state_q != ST_EMPTY);
   assign out_type    = main_q.typ;
   assign out_imm     = main_q.imm;
   assign out_tag     = main_q.tag;
   assign out_illegal = main_q.illegal;

   // Next-state and buffer steering.
   always_comb begin
      state_d  = state_q;
      main_d   = main_q;
      skid_d   = skid_q;
      new_s    = decode(in_inst, in_tag);
      accept_s = in_valid & in_ready;
      drain_s  = out_valid & out_ready;
      case (state_q)
         ST_EMPTY: begin
            if (accept_s) begin
               main_d  = new_s;
               state_d = ST_ONE;
            end else begin
               state_d = ST_EMPTY;
            end
         end
         ST_ONE: begin
            if (accept_s && drain_s) begin
               main_d = new_s;
            end else if (accept_s) begin
               skid_d  = new_s;
               state_d = ST_FULL;
            end else if (drain_s) begin
               state_d = ST_EMPTY;
            end else begin
               state_d = ST_ONE;
            end
         end
         ST_FULL: begin
            if (drain_s) begin
               main_d  = skid_q;
               state_d = ST_ONE;
            end else begin
               state_d = ST_FULL;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         state_d = state_d;
      end
   end

   // State and buffer registers; reset wins over flush.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         main_q  <= RST_ENTRY;
         skid_q  <= RST_ENTRY;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: an XLEN=64/CSR_EN=1 and an XLEN=32/CSR_EN=0 instance
// share stimulus; each is checked against an occupancy model and an arithmetic decoder.
module tb_imm_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_inst;
   logic [31:0] in_tag;
   logic        out_ready;

   logic        v_o  [2];
   logic        r_o  [2];
   logic        il_o [2];
   logic [2:0]  t_o  [2];
   logic [63:0] i_o  [2];
   logic [31:0] g_o  [2];
   logic [63:0] imm64;
   logic [31:0] imm32;

   int n_vec = 0;
   int n_err = 0;
   logic [63:0] sb0[$];
   logic [63:0] sb1[$];
   logic [31:0] drained[$];
   bit          acc_last;

   always #5 clk = ~clk;

   imm_decode_stage #(.XLEN(64), .TAG_W(32), .CSR_EN(1'b1)) u_d64 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(r_o[0]), .in_inst(in_inst), .in_tag(in_tag),
      .out_valid(v_o[0]), .out_ready(out_ready), .out_type(t_o[0]),
      .out_imm(imm64), .out_tag(g_o[0]), .out_illegal(il_o[0]));

   imm_decode_stage #(.XLEN(32), .TAG_W(32), .CSR_EN(1'b0)) u_d32 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(r_o[1]), .in_inst(in_inst), .in_tag(in_tag),
      .out_valid(v_o[1]), .out_ready(out_ready), .out_type(t_o[1]),
      .out_imm(imm32), .out_tag(g_o[1]), .out_illegal(il_o[1]));

   assign i_o[0] = imm64;
   assign i_o[1] = {32'd0, imm32};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference decoder: immediates rebuilt from field values with integer arithmetic.
   function automatic void ref_dec(input logic [31:0] inst, input int xlen, input bit csr,
                                   output logic [2:0] t, output logic [63:0] imm, output logic ill);
      longint s, u, v;
      s = longint'($signed(inst));
      u = longint'({32'd0, inst});
      t = 3'd7; ill = 1'b0; v = 0;
      case (inst[6:0])
         7'b0010011, 7'b0000011, 7'b1100111: t = 3'd3;
         7'b0011011: if (xlen == 64) t = 3'd3; else ill = 1'b1;
         7'b0110111, 7'b0010111: t = 3'd1;
         7'b1101111: t = 3'd2;
         7'b0100011: t = 3'd0;
         7'b1100011: t = 3'd4;
         7'b0110011: t = 3'd7;
         7'b0111011: if (xlen != 64) ill = 1'b1;
         7'b1110011: if (csr) t = inst[14] ? 3'd5 : 3'd3;
         default: ill = 1'b1;
      endcase
      case (t)
         3'd3: v = s >>> 20;
         3'd0: v = (s >>> 25) * 32 + ((u >> 7) & 31);
         3'd4: v = (s >>> 31) * 4096 + ((u >> 7) & 1) * 2048 + ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2;
         3'd1: v = (s >>> 12) * 4096;
         3'd2: v = (s >>> 31) * 1048576 + ((u >> 12) & 255) * 4096 + ((u >> 20) & 1) * 2048
                   + ((u >> 21) & 1023) * 2;
         3'd5: v = (u >> 15) & 31;
         default: v = 0;
      endcase
      imm = (xlen == 32) ? (64'(v) & 64'h0000_0000_FFFF_FFFF) : 64'(v);
   endfunction

   task automatic mon(input int k);
      int n; logic [63:0] e; logic [2:0] t; logic [63:0] im; logic il; string p;
      p = (k == 0) ? "x64" : "x32";
      n = (k == 0) ? sb0.size() : sb1.size();
      check({p, ".out_valid"}, 64'(v_o[k]), 64'(n > 0));
      check({p, ".in_ready"}, 64'(r_o[k]), 64'(n < 2));
      if (!rst_n || flush) begin
         if (k == 0) sb0.delete(); else sb1.delete();
         if (k == 0) acc_last = 1'b1;
      end else begin
         if (v_o[k] && out_ready && n > 0) begin
            e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
            ref_dec(e[31:0], (k == 0) ? 64 : 32, k == 0, t, im, il);
            check({p, ".type"}, 64'(t_o[k]), 64'(t));
            check({p, ".imm"}, i_o[k], im);
            check({p, ".illegal"}, 64'(il_o[k]), 64'(il));
            check({p, ".tag"}, 64'(g_o[k]), 64'(e[63:32]));
            if (k == 0) drained.push_back(g_o[k]);
         end
         if (in_valid && r_o[k]) begin
            if (k == 0) sb0.push_back({in_tag, in_inst}); else sb1.push_back({in_tag, in_inst});
         end
         if (k == 0) acc_last = in_valid && r_o[0];
      end
   endtask

   task automatic tick();
      @(negedge clk);
      mon(0); mon(1);
      @(posedge clk); #1;
   endtask

   task automatic beat(input logic [31:0] inst, input logic [31:0] tag);
      in_valid = 1'b1; in_inst = inst; in_tag = tag;
   endtask

   // inst, 64-bit {type, imm, ill}, 32-bit {type, imm, ill}
   logic [31:0] d_inst [10] = '{32'hFFF00093, 32'h123450B7, 32'h0080006F, 32'hFE000EE3, 32'h00112223,
                                32'h3002D073, 32'h00000000, 32'h0010009B, 32'h00000033, 32'h0000003B};
   logic [2:0]  d_t64  [10] = '{3'd3, 3'd1, 3'd2, 3'd4, 3'd0, 3'd5, 3'd7, 3'd3, 3'd7, 3'd7};
   logic [63:0] d_i64  [10] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_1234_5000, 64'd8,
                                64'hFFFF_FFFF_FFFF_FFFC, 64'd4, 64'd5, 64'd0, 64'd1, 64'd0, 64'd0};
   logic        d_l64  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   logic [2:0]  d_t32  [10] = '{3'd3, 3'd1, 3'd2, 3'd4, 3'd0, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
   logic [31:0] d_i32  [10] = '{32'hFFFF_FFFF, 32'h1234_5000, 32'd8, 32'hFFFF_FFFC, 32'd4,
                                32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
   logic        d_l32  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

   logic [6:0] ops [12] = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h37, 7'h17,
                            7'h6F, 7'h23, 7'h63, 7'h33, 7'h3B, 7'h73};

   initial begin
      logic [31:0] r;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = 32'd0; in_tag = 32'd0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check("rst.out_valid", 64'(v_o[k]), 64'd0);
         check("rst.in_ready", 64'(r_o[k]), 64'd1);
         check("rst.type", 64'(t_o[k]), 64'd7);
         check("rst.imm", i_o[k], 64'd0);
         check("rst.tag", 64'(g_o[k]), 64'd0);
         check("rst.illegal", 64'(il_o[k]), 64'd0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed decode sweep: result must be visible one cycle after accept.
      for (int i = 0; i < 10; i++) begin
         beat(d_inst[i], 32'(i + 100));
         tick();
         in_valid = 1'b0;
         @(negedge clk);
         check("dir.valid64", 64'(v_o[0]), 64'd1);
         check("dir.type64", 64'(t_o[0]), 64'(d_t64[i]));
         check("dir.imm64", i_o[0], d_i64[i]);
         check("dir.ill64", 64'(il_o[0]), 64'(d_l64[i]));
         check("dir.type32", 64'(t_o[1]), 64'(d_t32[i]));
         check("dir.imm32", i_o[1], 64'(d_i32[i]));
         check("dir.ill32", 64'(il_o[1]), 64'(d_l32[i]));
         mon(0); mon(1);
         @(posedge clk); #1;
      end

      // Backpressure: tags 1 and 2 fill the buffer, tag 3 waits upstream.
      drained.delete();
      out_ready = 1'b0;
      beat(32'h00100093, 32'd1); tick();
      beat(32'h00200093, 32'd2); tick();
      beat(32'h00300093, 32'd3);
      @(negedge clk);
      check("bp.in_ready", 64'(r_o[0]), 64'd0);
      check("bp.main_tag", 64'(g_o[0]), 64'd1);
      mon(0); mon(1);
      @(posedge clk); #1;
      tick();
      out_ready = 1'b1;
      tick(); tick();
      in_valid = 1'b0;
      tick(); tick();
      check("bp.count", 64'(drained.size()), 64'd3);
      for (int i = 0; i < 3 && i < drained.size(); i++) check("bp.order", 64'(drained[i]), 64'(i + 1));

      // Flush in FULL with a beat on the input.
      out_ready = 1'b0;
      beat(32'h00112223, 32'd10); tick();
      beat(32'h00112223, 32'd11); tick();
      flush = 1'b1; beat(32'h00112223, 32'd12); tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("fl.out_valid", 64'(v_o[0]), 64'd0);
      check("fl.in_ready", 64'(r_o[0]), 64'd1);
      mon(0); mon(1);
      @(posedge clk); #1;
      tick(); tick();

      // Reset together with flush while holding decoded data.
      out_ready = 1'b0;
      beat(32'h123450B7, 32'd20); tick();
      beat(32'h123450B7, 32'd21); tick();
      rst_n = 1'b0; flush = 1'b1; tick();
      rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check("rf.out_valid", 64'(v_o[k]), 64'd0);
         check("rf.in_ready", 64'(r_o[k]), 64'd1);
         check("rf.type", 64'(t_o[k]), 64'd7);
         check("rf.imm", i_o[k], 64'd0);
         check("rf.tag", 64'(g_o[k]), 64'd0);
         check("rf.illegal", 64'(il_o[k]), 64'd0);
      end
      mon(0); mon(1);
      @(posedge clk); #1;

      // Random traffic; an unaccepted beat is held until it is taken.
      acc_last = 1'b1;
      for (int c = 0; c < 10000; c++) begin
         if (acc_last || !in_valid) begin
            r = $urandom();
            in_inst = ($urandom_range(0, 12) == 12) ? r : {r[31:7], ops[$urandom_range(0, 11)]};
            in_tag  = $urandom();
            in_valid = ($urandom_range(0, 3) != 0);
         end
         out_ready = ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 255) == 0);
         tick();
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) tick();
      check("end.sb64_empty", 64'(sb0.size()), 64'd0);
      check("end.sb32_empty", 64'(sb1.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered immediate decoder for the NPC decode stage. Classifies a 32-bit RV32I/RV64I instruction by opcode, then extracts and sign- or zero-extends its immediate to `XLEN` bits. Replaces the purely combinational opcode-to-immediate-type mapping with a 1-cycle pipelined unit that carries a side-band tag and uses a valid/ready skid buffer. Sits between instruction fetch and the register-read/execute path.

## Interface
- `XLEN`, 64 — immediate output width; 32 or 64 only.
- `TAG_W`, 32 — width of pass-through tag (normally the PC).
- `CSR_EN`, 1 — 1: SYSTEM opcode is decoded (CSR I/Z forms); 0: SYSTEM is treated as NONE.

- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst_n` input 1 — synchronous, active-low reset.
- `flush` input 1 — synchronous; drops all buffered entries.
- `in_valid` input 1 — upstream beat valid.
- `in_ready` output 1 — unit can accept a beat.
- `in_inst` input 32 — instruction word.
- `in_tag` input TAG_W — side-band data, passed through unchanged.
- `out_valid` output 1 — output beat valid.
- `out_ready` input 1 — downstream accepts.
- `out_type` output 3 — immediate type code.
- `out_imm` output XLEN — extended immediate.
- `out_tag` output TAG_W — tag of the output beat.
- `out_illegal` output 1 — opcode not recognised.

## Operation
- Type codes: S=000, U=001, J=010, I=011, B=100, Z=101 (CSR zimm), NONE=111.
- Opcode map (`inst[6:0]`):
  - I-type: 0010011, 0000011, 1100111, 0011011 (RV64 only).
  - U-type: 0110111, 0010111.
  - J-type: 1101111.
  - S-type: 0100011.
  - B-type: 1100011.
  - NONE: 0110011, 0111011 (RV64 only).
  - SYSTEM 1110011 with `CSR_EN`=1: Z if `inst[14]`=1, otherwise I. With `CSR_EN`=0: NONE.
  - Any other opcode: NONE with `out_illegal`=1. 0011011 and 0111011 are illegal when `XLEN`=32.
- Immediate extraction; each result is sign-extended from its top bit to `XLEN`:
  - I: `inst[31:20]`.
  - S: {`inst[31:25]`, `inst[11:7]`}.
  - B: {`inst[31]`, `inst[7]`, `inst[30:25]`, `inst[11:8]`, 0}.
  - U: {`inst[31:12]`, 12'b0}, 32 bits.
  - J: {`inst[31]`, `inst[19:12]`, `inst[20]`, `inst[30:21]`, 0}.
- Z: `inst[19:15]` zero-extended.
- NONE: `out_imm` = 0.
- Shift-immediate forms decode as I; `inst[30]` stays in `out_imm` and downstream masks it.
- Storage: a 2-entry buffer made of a main (output) register plus a skid register.
  - Decode is performed before storage; both entries hold decoded results.
- State, encoded by (main_v, skid_v): EMPTY(0,0), ONE(1,0), FULL(1,1).
- Transitions (accept = `in_valid` & `in_ready`; drain = `out_valid` & `out_ready`):
  - EMPTY, accept → ONE.
  - ONE, accept & drain → ONE; main takes the new beat.
  - ONE, accept & no drain → FULL; the new beat goes to skid.
  - ONE, drain & no accept → EMPTY.
  - FULL, drain → ONE; skid moves to main.
  - FULL never accepts.
- `in_ready` = ~skid_v. It is a register output with no combinational path from `out_ready`.
- `out_valid` = main_v. All `out_*` fields come from the main register.
- `flush` (when `rst_n`=1) forces EMPTY in that cycle. Any beat presented in the same cycle is discarded.
- Reset (`rst_n`=0 at the edge) has priority over `flush`. Reset values:
  - `out_valid`=0, `in_ready`=1 (state EMPTY).
  - `out_type`=111, `out_imm`=0, `out_tag`=0, `out_illegal`=0.

## Timing
- Latency: 1 cycle from accept to `out_valid` when the unit is EMPTY or draining.
- Throughput: 1 beat/cycle while `out_ready`=1.
- While `out_valid`=1 & `out_ready`=0, all `out_*` fields are held stable.
- A beat accepted in the cycle `in_ready` deasserts is never lost, because capacity is 2.
- Reset mid-traffic takes effect at the next edge; partially buffered beats are dropped.

## Test plan
- Decode sweep, `XLEN`=64, `out_ready`=1:
  - 0xFFF00093 → type 011, imm 0xFFFFFFFFFFFFFFFF.
  - 0x123450B7 → type 001, imm 0x0000000012345000.
  - 0x0080006F → type 010, imm 8.
  - 0xFE000EE3 → type 100, imm 0xFFFFFFFFFFFFFFFC.
  - 0x00112223 → type 000, imm 4.
  - Each result appears exactly 1 cycle after accept.
- CSR: 0x3002D073 (csrrwi, zimm 5) → type 101, imm 5. With `CSR_EN`=0 → type 111, imm 0, illegal 0.
- Illegal: opcode 0000000 → type 111, `out_illegal`=1. With `XLEN`=32, 0x0010009B → `out_illegal`=1.
- Backpressure: hold `out_ready`=0 and drive 3 beats with tags 1, 2, 3.
  - Tag 1 is in main and tag 2 is in skid; `in_ready`=0 from the cycle after tag 2 is accepted; tag 3 is held upstream.
  - Release `out_ready`: tags emerge in order 1, 2, 3 with no loss or duplication.
- Flush and reset:
  - In state FULL, assert `flush` with `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, and the beat is discarded.
  - Assert `rst_n`=0 together with `flush` → all outputs take their reset values.
- Random traffic: 10k cycles with random `in_valid` and `out_ready`, checked against a scoreboard for in-order, lossless delivery and against a reference decoder for type and immediate.
